// File: rtl/mux_tree_pkg.sv
// Shared types and helpers for the analog mux-tree sequencer: FSM states, select decode, channel stepping.
package mux_tree_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        SWITCH,
        SETTLE,
        DONE,
        DWELL
    } state_t;

    // Level k select is simply address bits [k*SEL_W +: SEL_W], so the packed sel bus equals the address.
    function automatic logic [31:0] sel_decode(input logic [31:0] addr);
        return addr;
    endfunction

    function automatic logic [31:0] next_ch(input logic [31:0] addr, input int unsigned num_ch);
        return (addr + 32'd1 >= num_ch) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/mux_settle_timer.sv
// Loadable down-counter shared by the break, settle and dwell phases; start loads load_val.
// expire is high during the last of load_val cycles after the load edge (combinational, no backpressure).
module mux_settle_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/mux_tree_sequencer.sv
// Drives a LEVELS-deep tree of 2^SEL_W:1 analog muxes with break-before-make switching and a settle strobe.
// Accept to sample_stb is 2+BBM_CYC+SETTLE_CYC cycles; cmd_ready is low while busy or scanning, no queueing.
module mux_tree_sequencer
    import mux_tree_pkg::*;
#(
    parameter int  LEVELS     = 3,
    parameter int  SEL_W      = 3,
    parameter int  NUM_CH     = 48,
    parameter int  BBM_CYC    = 2,
    parameter int  SETTLE_CYC = 16,
    parameter int  DWELL_CYC  = 4,
    localparam int ADDR_W     = LEVELS * SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] sel,
    output logic              mux_en,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              settled,
    output logic              sample_stb,
    output logic              busy,
    output logic              err_range
);

    localparam int MAX_CYC = (BBM_CYC > SETTLE_CYC)
                           ? ((BBM_CYC > DWELL_CYC) ? BBM_CYC : DWELL_CYC)
                           : ((SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BBM_LD    = CNT_W'(BBM_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC);
    localparam logic [31:0]      NUM_CH_U  = NUM_CH;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] target, target_nxt, sel_nxt, cur_nxt, sw_tgt, ch_after;
    logic              mux_en_nxt, settled_nxt, stb_nxt, err_nxt;
    logic              tmr_start, tmr_expire, start_sw, cmd_legal;
    logic [CNT_W-1:0]  tmr_val;

    mux_settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign cmd_ready = (state == IDLE) && !scan_en;
    assign busy      = (state != IDLE);
    assign cmd_legal = (32'(cmd_addr) < NUM_CH_U);
    assign ch_after  = ADDR_W'(next_ch(32'(cur_addr), NUM_CH));

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        sel_nxt     = sel;
        cur_nxt     = cur_addr;
        mux_en_nxt  = mux_en;
        settled_nxt = settled;
        stb_nxt     = 1'b0;
        err_nxt     = 1'b0;
        tmr_start   = 1'b0;
        tmr_val     = '0;
        start_sw    = 1'b0;
        sw_tgt      = target;

        case (state)
            IDLE: begin
                if (scan_en) begin
                    start_sw = 1'b1;
                    sw_tgt   = settled ? ch_after : '0;
                end else if (cmd_valid) begin
                    if (!cmd_legal) begin
                        err_nxt = 1'b1;
                    end else if (cmd_addr == cur_addr && settled) begin
                        state_nxt = DONE;
                        stb_nxt   = 1'b1;
                    end else begin
                        start_sw = 1'b1;
                        sw_tgt   = cmd_addr;
                    end
                end
            end
            BREAK: begin
                if (tmr_expire) begin
                    state_nxt = SWITCH;
                    sel_nxt   = ADDR_W'(sel_decode(32'(target)));
                    cur_nxt   = target;
                end
            end
            SWITCH: begin
                state_nxt  = SETTLE;
                mux_en_nxt = 1'b1;
                tmr_start  = 1'b1;
                tmr_val    = SETTLE_LD;
            end
            SETTLE: begin
                if (tmr_expire) begin
                    state_nxt   = DONE;
                    settled_nxt = 1'b1;
                    stb_nxt     = 1'b1;
                end
            end
            DONE: begin
                if (!scan_en) begin
                    state_nxt = IDLE;
                end else if (DWELL_CYC == 0) begin
                    start_sw = 1'b1;
                    sw_tgt   = ch_after;
                end else begin
                    state_nxt = DWELL;
                    tmr_start = 1'b1;
                    tmr_val   = DWELL_LD;
                end
            end
            DWELL: begin
                // Scan stop during dwell leaves the channel routed and settled.
                if (!scan_en) begin
                    state_nxt = IDLE;
                end else if (tmr_expire) begin
                    start_sw = 1'b1;
                    sw_tgt   = ch_after;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start_sw) begin
            state_nxt   = BREAK;
            target_nxt  = sw_tgt;
            mux_en_nxt  = 1'b0;
            settled_nxt = 1'b0;
            tmr_start   = 1'b1;
            tmr_val     = BBM_LD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            sel        <= '0;
            cur_addr   <= '0;
            mux_en     <= 1'b0;
            settled    <= 1'b0;
            sample_stb <= 1'b0;
            err_range  <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            sel        <= sel_nxt;
            cur_addr   <= cur_nxt;
            mux_en     <= mux_en_nxt;
            settled    <= settled_nxt;
            sample_stb <= stb_nxt;
            err_range  <= err_nxt;
        end
    end

endmodule
